// File: rtl/machine_hpm_counter_unit.sv
// Machine counter unit: mcountinhibit, mcycle, minstret and NUM_HPM
// programmable hardware-performance counters with their event selectors.
// Decodes its own CSR addresses and returns read data combinationally.
module machine_hpm_counter_unit #(
   parameter int unsigned NUM_HPM             = 4,
   parameter int unsigned NUM_EVENTS          = 8,
   parameter int unsigned EVT_W               = 5,
   parameter logic [31:0] MCOUNTINHIBIT_RESET = 32'h0000_0000
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  wr_en_in,
   input  logic [11:0]           csr_addr_in,
   input  logic [31:0]           data_wr_in,
   input  logic                  instret_in,
   input  logic [NUM_EVENTS-1:0] hpm_event_in,
   output logic [31:0]           data_rd_out,
   output logic                  addr_hit_out,
   output logic [31:0]           mcountinhibit_out
);

   // Arrays keep at least one entry so NUM_HPM = 0 still elaborates.
   localparam int unsigned HPM_N = (NUM_HPM > 0) ? NUM_HPM : 1;

   localparam logic [11:0] ADDR_INHIBIT  = 12'h320;
   localparam logic [11:0] ADDR_EVT_BASE = 12'h323;
   localparam logic [11:0] ADDR_CYC_LO   = 12'hB00;
   localparam logic [11:0] ADDR_CYC_HI   = 12'hB80;
   localparam logic [11:0] ADDR_INS_LO   = 12'hB02;
   localparam logic [11:0] ADDR_INS_HI   = 12'hB82;
   localparam logic [11:0] ADDR_HPM_LO   = 12'hB03;
   localparam logic [11:0] ADDR_HPM_HI   = 12'hB83;

   // Writable inhibit bits: CY (0), IR (2) and one bit per implemented HPM.
   function automatic logic [31:0] inhibit_mask(input int unsigned n_hpm);
      logic [31:0] m;
      m = 32'h0000_0005;
      for (int unsigned k = 0; k < 29; k++) begin
         m[5'(k + 32'd3)] = (k < n_hpm);
      end
      return m;
   endfunction

   localparam logic [31:0] INH_MASK = inhibit_mask(NUM_HPM);

   logic [31:0]      r_mcountinhibit;
   logic [63:0]      r_mcycle;
   logic [63:0]      r_minstret;
   logic [63:0]      r_hpm_cnt [HPM_N];
   logic [EVT_W-1:0] r_hpm_evt [HPM_N];

   logic             w_wr_inh;
   logic             w_wr_cyc_lo;
   logic             w_wr_cyc_hi;
   logic             w_wr_ins_lo;
   logic             w_wr_ins_hi;
   logic [HPM_N-1:0] w_wr_evt;
   logic [HPM_N-1:0] w_wr_hpm_lo;
   logic [HPM_N-1:0] w_wr_hpm_hi;
   logic [HPM_N-1:0] w_evt_hit;
   logic [HPM_N-1:0] w_hpm_inc;
   logic [31:0]      w_rd_data;
   logic             w_rd_hit;

   // Write strobe decode: only implemented registers ever see a write.
   always_comb begin
      w_wr_inh    = wr_en_in && (csr_addr_in == ADDR_INHIBIT);
      w_wr_cyc_lo = wr_en_in && (csr_addr_in == ADDR_CYC_LO);
      w_wr_cyc_hi = wr_en_in && (csr_addr_in == ADDR_CYC_HI);
      w_wr_ins_lo = wr_en_in && (csr_addr_in == ADDR_INS_LO);
      w_wr_ins_hi = wr_en_in && (csr_addr_in == ADDR_INS_HI);
      w_wr_evt    = {HPM_N{1'b0}};
      w_wr_hpm_lo = {HPM_N{1'b0}};
      w_wr_hpm_hi = {HPM_N{1'b0}};
      for (int unsigned i = 0; i < NUM_HPM; i++) begin
         w_wr_evt[i]    = wr_en_in && (csr_addr_in == ADDR_EVT_BASE + 12'(i));
         w_wr_hpm_lo[i] = wr_en_in && (csr_addr_in == ADDR_HPM_LO + 12'(i));
         w_wr_hpm_hi[i] = wr_en_in && (csr_addr_in == ADDR_HPM_HI + 12'(i));
      end
   end

   // Event selection: code k picks strobe k-1; code 0 or out-of-range codes match nothing.
   always_comb begin
      w_evt_hit = {HPM_N{1'b0}};
      w_hpm_inc = {HPM_N{1'b0}};
      for (int unsigned i = 0; i < NUM_HPM; i++) begin
         for (int unsigned k = 1; k <= NUM_EVENTS; k++) begin
            w_evt_hit[i] = w_evt_hit[i] |
                           ((r_hpm_evt[i] == EVT_W'(k)) & hpm_event_in[k-1]);
         end
         w_hpm_inc[i] = w_evt_hit[i] & ~r_mcountinhibit[5'(i + 32'd3)];
      end
   end

   // Inhibit register; a write only affects counting from the next cycle.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_mcountinhibit <= MCOUNTINHIBIT_RESET & INH_MASK;
      end else if (w_wr_inh) begin
         r_mcountinhibit <= data_wr_in & INH_MASK;
      end else begin
         r_mcountinhibit <= r_mcountinhibit;
      end
   end

   // mcycle: a half-write wins over the increment; the carry crosses halves in one cycle.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_mcycle <= 64'h0;
      end else if (w_wr_cyc_lo) begin
         r_mcycle <= {r_mcycle[63:32], data_wr_in};
      end else if (w_wr_cyc_hi) begin
         r_mcycle <= {data_wr_in, r_mcycle[31:0]};
      end else if (!r_mcountinhibit[0]) begin
         r_mcycle <= r_mcycle + 64'd1;
      end else begin
         r_mcycle <= r_mcycle;
      end
   end

   // minstret: counts retire strobes unless inhibited; a half-write wins.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_minstret <= 64'h0;
      end else if (w_wr_ins_lo) begin
         r_minstret <= {r_minstret[63:32], data_wr_in};
      end else if (w_wr_ins_hi) begin
         r_minstret <= {data_wr_in, r_minstret[31:0]};
      end else if (instret_in && !r_mcountinhibit[2]) begin
         r_minstret <= r_minstret + 64'd1;
      end else begin
         r_minstret <= r_minstret;
      end
   end

   // HPM counters and their event selectors.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int unsigned i = 0; i < HPM_N; i++) begin
            r_hpm_cnt[i] <= 64'h0;
            r_hpm_evt[i] <= {EVT_W{1'b0}};
         end
      end else begin
         for (int unsigned i = 0; i < NUM_HPM; i++) begin
            if (w_wr_evt[i]) begin
               r_hpm_evt[i] <= data_wr_in[EVT_W-1:0];
            end else begin
               r_hpm_evt[i] <= r_hpm_evt[i];
            end
            if (w_wr_hpm_lo[i]) begin
               r_hpm_cnt[i] <= {r_hpm_cnt[i][63:32], data_wr_in};
            end else if (w_wr_hpm_hi[i]) begin
               r_hpm_cnt[i] <= {data_wr_in, r_hpm_cnt[i][31:0]};
            end else if (w_hpm_inc[i]) begin
               r_hpm_cnt[i] <= r_hpm_cnt[i] + 64'd1;
            end else begin
               r_hpm_cnt[i] <= r_hpm_cnt[i];
            end
         end
      end
   end

   // Combinational read mux; unmapped or unimplemented addresses read 0 with no hit.
   always_comb begin
      w_rd_data = 32'h0;
      w_rd_hit  = 1'b0;
      case (csr_addr_in)
         ADDR_INHIBIT: begin w_rd_data = r_mcountinhibit;    w_rd_hit = 1'b1; end
         ADDR_CYC_LO:  begin w_rd_data = r_mcycle[31:0];     w_rd_hit = 1'b1; end
         ADDR_CYC_HI:  begin w_rd_data = r_mcycle[63:32];    w_rd_hit = 1'b1; end
         ADDR_INS_LO:  begin w_rd_data = r_minstret[31:0];   w_rd_hit = 1'b1; end
         ADDR_INS_HI:  begin w_rd_data = r_minstret[63:32];  w_rd_hit = 1'b1; end
         default:      begin w_rd_data = 32'h0;              w_rd_hit = 1'b0; end
      endcase
      for (int unsigned i = 0; i < NUM_HPM; i++) begin
         if (csr_addr_in == ADDR_EVT_BASE + 12'(i)) begin
            w_rd_data = {{(32-EVT_W){1'b0}}, r_hpm_evt[i]};
            w_rd_hit  = 1'b1;
         end else if (csr_addr_in == ADDR_HPM_LO + 12'(i)) begin
            w_rd_data = r_hpm_cnt[i][31:0];
            w_rd_hit  = 1'b1;
         end else if (csr_addr_in == ADDR_HPM_HI + 12'(i)) begin
            w_rd_data = r_hpm_cnt[i][63:32];
            w_rd_hit  = 1'b1;
         end else begin
            w_rd_data = w_rd_data;
            w_rd_hit  = w_rd_hit;
         end
      end
   end

   assign data_rd_out       = w_rd_data;
   assign addr_hit_out      = w_rd_hit;
   assign mcountinhibit_out = r_mcountinhibit;

endmodule

// File: tb/tb_machine_hpm_counter_unit.sv
`timescale 1ns/1ps
// Bench for machine_hpm_counter_unit: a register-file model indexed by counter
// number (0=mcycle, 2=minstret, 3..=HPM) is checked every cycle, plus
// hand-computed literal reads that pin the model.
module tb_machine_hpm_counter_unit;

   localparam int NUM_HPM    = 4;
   localparam int NUM_EVENTS = 8;
   localparam int EVT_W      = 5;

   logic                  clk_in = 1'b0;
   logic                  rst_n_in;
   logic                  wr_en_in;
   logic [11:0]           csr_addr_in;
   logic [31:0]           data_wr_in;
   logic                  instret_in;
   logic [NUM_EVENTS-1:0] hpm_event_in;
   logic [31:0]           data_rd_out;
   logic                  addr_hit_out;
   logic [31:0]           mcountinhibit_out;

   int errors = 0;
   int checks = 0;

   machine_hpm_counter_unit #(
      .NUM_HPM(NUM_HPM), .NUM_EVENTS(NUM_EVENTS), .EVT_W(EVT_W),
      .MCOUNTINHIBIT_RESET(32'h0000_0000)
   ) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .wr_en_in(wr_en_in),
      .csr_addr_in(csr_addr_in), .data_wr_in(data_wr_in),
      .instret_in(instret_in), .hpm_event_in(hpm_event_in),
      .data_rd_out(data_rd_out), .addr_hit_out(addr_hit_out),
      .mcountinhibit_out(mcountinhibit_out)
   );

   always #50 clk_in = ~clk_in;

   // ---------------- model ----------------
   logic [63:0]      m_cnt [32];
   logic [63:0]      m_nxt [32];
   logic [EVT_W-1:0] m_evt [32];
   logic [31:0]      m_inh;

   function automatic bit impl(input int idx);
      return (idx == 0) || (idx == 2) || (idx >= 3 && idx < 3 + NUM_HPM);
   endfunction

   function automatic logic [31:0] impl_mask();
      logic [31:0] m;
      m = 32'h0;
      for (int k = 0; k < 32; k++) if (impl(k)) m[k] = 1'b1;
      return m;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 32; k++) begin
         m_cnt[k] = 64'h0;
         m_evt[k] = '0;
      end
      m_inh = 32'h0;
   endtask

   task automatic model_rd(input logic [11:0] a, output logic [31:0] d, output logic h);
      int idx;
      d = 32'h0;
      h = 1'b0;
      if (a == 12'h320) begin
         d = m_inh; h = 1'b1;
      end else if (a >= 12'h323 && a <= 12'h33F) begin
         idx = int'(a - 12'h320);
         if (impl(idx)) begin d = {{(32-EVT_W){1'b0}}, m_evt[idx]}; h = 1'b1; end
      end else if (a >= 12'hB00 && a <= 12'hB1F) begin
         idx = int'(a - 12'hB00);
         if (impl(idx)) begin d = m_cnt[idx][31:0]; h = 1'b1; end
      end else if (a >= 12'hB80 && a <= 12'hB9F) begin
         idx = int'(a - 12'hB80);
         if (impl(idx)) begin d = m_cnt[idx][63:32]; h = 1'b1; end
      end
   endtask

   always @(negedge rst_n_in) model_clear();

   // Model state update: increments use pre-write inhibit/selectors; a written half wins.
   always @(posedge clk_in) begin : model_upd
      logic [31:0] inh_n;
      logic [11:0] a;
      int idx;
      int code;
      bit inc;
      if (!rst_n_in) begin
         model_clear();
      end else begin
         for (int k = 0; k < 32; k++) begin
            inc = 1'b0;
            if (impl(k) && !m_inh[k]) begin
               if (k == 0) inc = 1'b1;
               else if (k == 2) inc = instret_in;
               else begin
                  code = int'(m_evt[k]);
                  for (int e = 1; e <= NUM_EVENTS; e++)
                     if (code == e) inc = hpm_event_in[e-1];
               end
            end
            m_nxt[k] = m_cnt[k] + (inc ? 64'd1 : 64'd0);
         end
         inh_n = m_inh;
         if (wr_en_in) begin
            a = csr_addr_in;
            if (a == 12'h320) begin
               inh_n = data_wr_in & impl_mask();
            end else if (a >= 12'h323 && a <= 12'h33F) begin
               idx = int'(a - 12'h320);
               if (impl(idx)) m_evt[idx] = data_wr_in[EVT_W-1:0];
            end else if (a >= 12'hB00 && a <= 12'hB1F) begin
               idx = int'(a - 12'hB00);
               if (impl(idx)) m_nxt[idx] = {m_cnt[idx][63:32], data_wr_in};
            end else if (a >= 12'hB80 && a <= 12'hB9F) begin
               idx = int'(a - 12'hB80);
               if (impl(idx)) m_nxt[idx] = {data_wr_in, m_cnt[idx][31:0]};
            end
         end
         m_inh = inh_n;
         for (int k = 0; k < 32; k++) m_cnt[k] = m_nxt[k];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk_in) begin : cmp
      logic [31:0] ed;
      logic eh;
      model_rd(csr_addr_in, ed, eh);
      chk("cyc_rd_data", {32'h0, data_rd_out}, {32'h0, ed});
      chk("cyc_addr_hit", {63'h0, addr_hit_out}, {63'h0, eh});
      chk("cyc_inhibit", {32'h0, mcountinhibit_out}, {32'h0, m_inh});
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input logic wr, input logic [11:0] a, input logic [31:0] d,
                      input logic ir, input logic [7:0] ev);
      wr_en_in = wr; csr_addr_in = a; data_wr_in = d; instret_in = ir; hpm_event_in = ev;
      @(posedge clk_in); #1;
      wr_en_in = 1'b0; instret_in = 1'b0; hpm_event_in = 8'h00;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, csr_addr_in, 32'h0, 1'b0, 8'h00);
   endtask

   task automatic lit(input string n, input logic [11:0] a, input logic [31:0] e, input logic eh);
      csr_addr_in = a;
      #1;
      chk(n, {32'h0, data_rd_out}, {32'h0, e});
      chk({n, "_hit"}, {63'h0, addr_hit_out}, {63'h0, eh});
   endtask

   initial begin
      rst_n_in = 1'b1; wr_en_in = 1'b0; csr_addr_in = 12'hB00; data_wr_in = 32'h0;
      instret_in = 1'b0; hpm_event_in = 8'h00;
      #1 rst_n_in = 1'b0;
      @(posedge clk_in); @(posedge clk_in); #1;
      rst_n_in = 1'b1;

      // Reset release then 10 idle cycles
      idle(10);
      lit("cycle_after_10", 12'hB00, 32'd10, 1'b1);
      lit("cycle_hi_0", 12'hB80, 32'd0, 1'b1);
      lit("instret_0", 12'hB02, 32'd0, 1'b1);
      lit("hpm3_0", 12'hB03, 32'd0, 1'b1);
      lit("hpm6_0", 12'hB06, 32'd0, 1'b1);
      lit("inhibit_0", 12'h320, 32'd0, 1'b1);

      // Inhibit all: only implemented bits stick; write cycle still counts
      cyc(1'b1, 12'h320, 32'hFFFF_FFFF, 1'b0, 8'h00);
      lit("inhibit_rb", 12'h320, 32'h0000_007D, 1'b1);
      chk("inhibit_out", {32'h0, mcountinhibit_out}, 64'h7D);
      lit("cycle_write_cyc", 12'hB00, 32'd11, 1'b1);
      idle(5);
      lit("cycle_held", 12'hB00, 32'd11, 1'b1);
      cyc(1'b1, 12'h320, 32'h0, 1'b0, 8'h00);
      lit("cycle_still_held", 12'hB00, 32'd11, 1'b1);
      idle(1);
      lit("cycle_resumed", 12'hB00, 32'd12, 1'b1);

      // 64-bit wrap with halves written separately
      cyc(1'b1, 12'hB80, 32'hFFFF_FFFF, 1'b0, 8'h00);
      lit("cyc_hi_written", 12'hB80, 32'hFFFF_FFFF, 1'b1);
      lit("cyc_lo_no_inc", 12'hB00, 32'd12, 1'b1);
      cyc(1'b1, 12'hB00, 32'hFFFF_FFFE, 1'b0, 8'h00);
      lit("cyc_lo_written", 12'hB00, 32'hFFFF_FFFE, 1'b1);
      idle(1);
      lit("cyc_lo_max", 12'hB00, 32'hFFFF_FFFF, 1'b1);
      lit("cyc_hi_max", 12'hB80, 32'hFFFF_FFFF, 1'b1);
      idle(1);
      lit("cyc_lo_wrap", 12'hB00, 32'h0, 1'b1);
      lit("cyc_hi_wrap", 12'hB80, 32'h0, 1'b1);

      // HPM event selection
      cyc(1'b1, 12'h323, 32'd3, 1'b0, 8'h00);
      for (int i = 0; i < 4; i++) cyc(1'b0, 12'hB03, 32'h0, 1'b0, 8'h04);
      for (int i = 0; i < 3; i++) cyc(1'b0, 12'hB03, 32'h0, 1'b0, 8'h01);
      lit("hpm3_sel3", 12'hB03, 32'd4, 1'b1);
      cyc(1'b1, 12'h324, 32'd0, 1'b0, 8'h00);
      cyc(1'b0, 12'hB04, 32'h0, 1'b0, 8'hFF);
      lit("hpm4_code0", 12'hB04, 32'd0, 1'b1);
      lit("hpm3_allev", 12'hB03, 32'd5, 1'b1);
      cyc(1'b1, 12'h325, 32'hFFFF_FFE8, 1'b0, 8'h00);
      lit("evt5_masked", 12'h325, 32'd8, 1'b1);
      cyc(1'b1, 12'h326, 32'd9, 1'b0, 8'h00);
      lit("evt6_rb", 12'h326, 32'd9, 1'b1);
      cyc(1'b0, 12'hB05, 32'h0, 1'b0, 8'h80);
      lit("hpm5_code8", 12'hB05, 32'd1, 1'b1);
      lit("hpm6_code9", 12'hB06, 32'd0, 1'b1);
      // HPM inhibit: write cycle uses old value in both directions
      cyc(1'b1, 12'h320, 32'h0000_0008, 1'b0, 8'h04);
      lit("hpm3_inh_wr", 12'hB03, 32'd6, 1'b1);
      cyc(1'b0, 12'hB03, 32'h0, 1'b0, 8'h04);
      cyc(1'b1, 12'h320, 32'h0, 1'b0, 8'h04);
      lit("hpm3_inh_held", 12'hB03, 32'd6, 1'b1);
      cyc(1'b0, 12'hB03, 32'h0, 1'b0, 8'h04);
      lit("hpm3_resumed", 12'hB03, 32'd7, 1'b1);

      // minstret: write wins over a simultaneous retire
      cyc(1'b1, 12'hB02, 32'h100, 1'b1, 8'h00);
      lit("instret_wr", 12'hB02, 32'h100, 1'b1);
      cyc(1'b0, 12'hB02, 32'h0, 1'b1, 8'h00);
      lit("instret_inc", 12'hB02, 32'h101, 1'b1);
      cyc(1'b1, 12'hB82, 32'h0000_000A, 1'b1, 8'h00);
      lit("instret_hi_wr", 12'hB82, 32'h0000_000A, 1'b1);
      lit("instret_lo_hold", 12'hB02, 32'h101, 1'b1);

      // Unimplemented and unmapped addresses
      lit("unimpl_b07", 12'hB07, 32'h0, 1'b0);
      lit("unimpl_327", 12'h327, 32'h0, 1'b0);
      lit("unmap_321", 12'h321, 32'h0, 1'b0);
      lit("unmap_b01", 12'hB01, 32'h0, 1'b0);
      lit("hpm6_hi", 12'hB86, 32'h0, 1'b1);
      cyc(1'b1, 12'hB07, 32'd5, 1'b0, 8'h00);
      lit("unimpl_b07_wr", 12'hB07, 32'h0, 1'b0);

      // Asynchronous reset mid-count, no clock edge needed
      cyc(1'b1, 12'h320, 32'h0000_0010, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) cyc(1'b0, 12'hB03, 32'h0, 1'b1, 8'h04);
      #1 rst_n_in = 1'b0;
      lit("rst_cycle", 12'hB00, 32'h0, 1'b1);
      lit("rst_instret", 12'hB02, 32'h0, 1'b1);
      lit("rst_hpm3", 12'hB03, 32'h0, 1'b1);
      lit("rst_evt3", 12'h323, 32'h0, 1'b1);
      chk("rst_inhibit_out", {32'h0, mcountinhibit_out}, 64'h0);
      wr_en_in = 1'b1; csr_addr_in = 12'hB00; data_wr_in = 32'h55;
      instret_in = 1'b1; hpm_event_in = 8'hFF;
      @(posedge clk_in); #1;
      chk("rst_hold_data", {32'h0, data_rd_out}, 64'h0);
      wr_en_in = 1'b0; instret_in = 1'b0; hpm_event_in = 8'h00;
      rst_n_in = 1'b1;
      idle(3);
      lit("post_rst_cycle", 12'hB00, 32'd3, 1'b1);
      lit("post_rst_instret", 12'hB02, 32'd0, 1'b1);

      idle(1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/machine_hpm_counter_unit.md
Name: machine_hpm_counter_unit

Overview:
- Parametrised successor to the single-register inhibit block.
- Holds mcountinhibit, the 64-bit mcycle and minstret counters, NUM_HPM programmable hardware-performance counters (mhpmcounter3..) and their mhpmevent selectors.
- Sits beside the CSR file: it decodes its own CSR addresses, takes event strobes from the pipeline and returns read data combinationally.

Parameters:
- NUM_HPM, 4, number of implemented mhpmcounter/mhpmevent pairs (0..29), mapped to indices 3..3+NUM_HPM-1.
- NUM_EVENTS, 8, width of hpm_event_in; event code 0 means "count nothing".
- EVT_W, 5, width of each mhpmevent selector field (bits [EVT_W-1:0] of the CSR).
- MCOUNTINHIBIT_RESET, 32'h0, reset value of implemented inhibit bits.

Ports:
- clk_in  in  1  clock, rising edge.
- rst_n_in  in  1  reset, asynchronous, active-low; asserts immediately, releases synchronously to clk_in.
- wr_en_in  in  1  CSR write strobe.
- csr_addr_in  in  12  CSR address.
- data_wr_in  in  32  CSR write data.
- instret_in  in  1  one instruction retired this cycle.
- hpm_event_in  in  NUM_EVENTS  event strobes; bit k is event code k+1.
- data_rd_out  out  32  combinational read data for csr_addr_in.
- addr_hit_out  out  1  csr_addr_in maps to an implemented register in this unit.
- mcountinhibit_out  out  32  current inhibit register.

Behaviour:
- Reset: all counters, all mhpmevent registers and mcountinhibit are 0 (mcountinhibit takes MCOUNTINHIBIT_RESET masked to implemented bits).
- Address map:
  - 0x320 mcountinhibit.
  - 0x323+i mhpmevent(3+i).
  - 0xB00 / 0xB80 mcycle low / high.
  - 0xB02 / 0xB82 minstret low / high.
  - 0xB03+i / 0xB83+i mhpmcounter(3+i) low / high, for i < NUM_HPM.
- Unimplemented indices: addresses for i >= NUM_HPM read 0, ignore writes and give addr_hit_out=0. Any address outside the map also reads 0 with addr_hit_out=0.
- mcountinhibit: bit0=CY, bit2=IR, bits 3..3+NUM_HPM-1 = HPM. Bit1 and unimplemented bits are hardwired 0 (write-ignored).
- mhpmevent: only [EVT_W-1:0] is stored; upper bits read 0. Code 0 or code > NUM_EVENTS never counts.
- Counting, evaluated every cycle, registered at the next edge (1-cycle latency):
  - mcycle += 1 unless CY inhibited.
  - minstret += instret_in unless IR inhibited.
  - mhpmcounter(3+i) += 1 when its selected event strobe is 1 and its HPM bit is 0.
- All counters are 64-bit and wrap from 2^64-1 to 0 silently. The low-to-high carry occurs in the same cycle.
- CSR write to a counter half:
  - The written half takes data_wr_in.
  - The other half holds its value.
  - The counter does not increment in that cycle (write wins over the event).
- Write to mcountinhibit or mhpmevent takes effect on counting from the following cycle. The write cycle itself still uses the old value.
- Reads are combinational from current register state. A read in the same cycle as a write returns the pre-write value.
- Reset mid-count: asynchronous clear of all state regardless of wr_en_in and events; the first increment is at the first clock edge after release.

Test Plan:
- Reset release, all inhibits 0, 10 idle cycles -> mcycle reads 10; minstret and all hpm counters read 0; mcountinhibit reads 0.
- Write 0x320 with 0xFFFFFFFF (NUM_HPM=4) -> reads back 0x0000007D; mcycle holds for 5 cycles. Write 0 -> mcycle increments again from the cycle after the write.
- Write 0xB80=0xFFFFFFFF, then 0xB00=0xFFFFFFFE -> next cycle mcycle low=0xFFFFFFFF, high=0xFFFFFFFF; following cycle low=0, high=0 (wrap).
- Write 0x323=3, pulse hpm_event_in[2] 4 times and hpm_event_in[0] 3 times -> 0xB03 reads 4. Write 0x324=0, pulse every event -> 0xB04 stays 0.
- instret_in high on the same cycle as a write 0xB02=0x100 -> minstret low reads 0x100, not 0x101. The next retire gives 0x101.
- Read 0xB07 / 0x327 with NUM_HPM=4 -> data 0, addr_hit_out=0. Assert rst_n_in low mid-count with no clock edge -> all reads 0 immediately.
